// File: rtl/avalon_mult_pkg.sv
// Shared types and constants for the Avalon-MM multiplier scheduler.
// Address map of the multiplier slave: two halfwords per operand, four per product.
package avalon_mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WAIT,
    ST_RD,
    ST_RLAST
  } state_t;

  typedef struct packed {
    state_t     state;
    logic       last_grant;
    logic [1:0] beat;
  } dbg_t;

  localparam logic [3:0] ADDR_A0 = 4'd0;
  localparam logic [3:0] ADDR_A1 = 4'd1;
  localparam logic [3:0] ADDR_B0 = 4'd2;
  localparam logic [3:0] ADDR_B1 = 4'd3;
  localparam logic [3:0] ADDR_C0 = 4'd4;
  localparam logic [3:0] ADDR_C1 = 4'd5;
  localparam logic [3:0] ADDR_C2 = 4'd6;
  localparam logic [3:0] ADDR_C3 = 4'd7;

  localparam int NBEATS = 4;

  // Halfword written on a given write beat: A lo, A hi, B lo, B hi.
  function automatic logic [15:0] wr_word(input logic [1:0] beat,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [15:0] w;
    case (beat)
      2'd0:    w = a[15:0];
      2'd1:    w = a[31:16];
      2'd2:    w = b[15:0];
      default: w = b[31:16];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; last_grant moves only when the grant is taken.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       _rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant,
  output logic       last_grant
);

  // A lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant = ~last_grant;
    if (req == 2'b01)      grant = 1'b0;
    else if (req == 2'b10) grant = 1'b1;
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst)        last_grant <= 1'b1;
    else if (advance) last_grant <= grant;
  end

endmodule

// File: rtl/avalon_mm_mult_scheduler.sv
// Shares one Avalon-MM multiplier slave between two clients: arbitrate, write
// the operands, wait out the multiplier latency, read the product, respond.
module avalon_mm_mult_scheduler
  import avalon_mult_pkg::*;
#(
  parameter int SZ       = 32,
  parameter int WAIT_CYC = 4
) (
  input  logic            clk,
  input  logic            _rst,
  input  logic            req0_valid,
  input  logic [SZ-1:0]   req0_a,
  input  logic [SZ-1:0]   req0_b,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [SZ-1:0]   req1_a,
  input  logic [SZ-1:0]   req1_b,
  output logic            req1_ready,
  output logic            rsp0_valid,
  output logic [2*SZ-1:0] rsp0_res,
  output logic            rsp1_valid,
  output logic [2*SZ-1:0] rsp1_res,
  output logic [3:0]      addr,
  output logic            read,
  output logic            write,
  output logic [15:0]     write_data,
  input  logic [15:0]     read_data,
  output logic            busy,
  output dbg_t            dbg
);

  // Handshake: a request transfers on the rising edge where reqN_valid && reqN_ready;
  // ready is combinational and never waits on anything but state and grant.
  localparam logic [1:0] LAST_BEAT = 2'(NBEATS - 1);
  localparam logic [7:0] WAIT_LOAD = (WAIT_CYC == 0) ? 8'd0 : 8'(WAIT_CYC - 1);

  state_t          state, state_d;
  logic [1:0]      beat, beat_d, beat_n;
  logic [7:0]      cnt, cnt_d;
  logic [SZ-1:0]   a_q, b_q, sel_a, sel_b;
  logic            owner;
  logic [47:0]     acc;
  logic            grant, last_grant, accept, rsp_fire;
  logic [3:0]      addr_d;
  logic            read_d, write_d;
  logic [15:0]     wdata_d;

  rr_arbiter_2 u_arb (
    .clk        (clk),
    ._rst       (_rst),
    .req        ({req1_valid, req0_valid}),
    .advance    (accept),
    .grant      (grant),
    .last_grant (last_grant)
  );

  assign req0_ready = (state == ST_IDLE) && !grant && req0_valid;
  assign req1_ready = (state == ST_IDLE) &&  grant && req1_valid;
  assign accept     = req0_ready || req1_ready;
  assign sel_a      = grant ? req1_a : req0_a;
  assign sel_b      = grant ? req1_b : req0_b;
  assign dbg        = '{state: state, last_grant: last_grant, beat: beat};

  // Bus outputs are computed one cycle ahead so the registered strobes line
  // up with the state that owns them.
  always_comb begin
    state_d  = state;
    beat_d   = beat;
    cnt_d    = cnt;
    addr_d   = ADDR_A0;
    read_d   = 1'b0;
    write_d  = 1'b0;
    wdata_d  = 16'd0;
    rsp_fire = 1'b0;
    beat_n   = beat + 2'd1;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WR;
          beat_d  = 2'd0;
          write_d = 1'b1;
          addr_d  = ADDR_A0;
          wdata_d = wr_word(2'd0, sel_a, sel_b);
        end
      end
      ST_WR: begin
        if (beat != LAST_BEAT) begin
          beat_d  = beat_n;
          write_d = 1'b1;
          addr_d  = ADDR_A0 + 4'(beat_n);
          wdata_d = wr_word(beat_n, a_q, b_q);
        end else if (WAIT_CYC == 0) begin
          state_d = ST_RD;
          beat_d  = 2'd0;
          read_d  = 1'b1;
          addr_d  = ADDR_C0;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt == 8'd0) begin
          state_d = ST_RD;
          beat_d  = 2'd0;
          read_d  = 1'b1;
          addr_d  = ADDR_C0;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      ST_RD: begin
        if (beat != LAST_BEAT) begin
          beat_d = beat_n;
          read_d = 1'b1;
          addr_d = ADDR_C0 + 4'(beat_n);
        end else begin
          state_d = ST_RLAST;
        end
      end
      ST_RLAST: begin
        state_d  = ST_IDLE;
        rsp_fire = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state <= ST_IDLE;
      beat  <= 2'd0;
      cnt   <= 8'd0;
    end else begin
      state <= state_d;
      beat  <= beat_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      a_q        <= '0;
      b_q        <= '0;
      owner      <= 1'b0;
      acc        <= 48'd0;
      addr       <= 4'd0;
      read       <= 1'b0;
      write      <= 1'b0;
      write_data <= 16'd0;
      busy       <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_res   <= '0;
      rsp1_res   <= '0;
    end else begin
      addr       <= addr_d;
      read       <= read_d;
      write      <= write_d;
      write_data <= wdata_d;
      busy       <= (state_d != ST_IDLE);
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (accept) begin
        a_q   <= sel_a;
        b_q   <= sel_b;
        owner <= grant;
      end
      // read_data trails the read strobe by a cycle, so RD beat n holds C(n-1).
      if (state == ST_RD) begin
        case (beat)
          2'd1:    acc[15:0]  <= read_data;
          2'd2:    acc[31:16] <= read_data;
          2'd3:    acc[47:32] <= read_data;
          default: ;
        endcase
      end
      if (rsp_fire) begin
        if (!owner) begin
          rsp0_valid <= 1'b1;
          rsp0_res   <= {read_data, acc};
        end else begin
          rsp1_valid <= 1'b1;
          rsp1_res   <= {read_data, acc};
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_mm_mult_scheduler.sv
// Bench for avalon_mm_mult_scheduler: two instances (WAIT_CYC=4 and 0), each
// against a behavioural multiplier slave, with a cycle-level reference model.
`timescale 1ns/1ps
module tb_avalon_mm_mult_scheduler;
  import avalon_mult_pkg::*;

  localparam int W0 = 4;
  localparam int W1 = 0;

  logic        clk, _rst;
  logic        rv   [2][2];
  logic [31:0] ra   [2][2];
  logic [31:0] rb   [2][2];
  logic        rr   [2][2];
  logic        sv   [2][2];
  logic [63:0] sres [2][2];
  logic [3:0]  addr  [2];
  logic        rd    [2];
  logic        wr    [2];
  logic        busy  [2];
  logic [15:0] wdata [2];
  logic [15:0] rdata [2];
  dbg_t        dbg   [2];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_accept = 0;
  longint      cyc      = 0;

  // Expected responses: {inst, port, due cycle[31:0], product[63:0]}
  logic [97:0] exp_q[$];
  logic [19:0] wlog[$];
  logic [15:0] sregs [2][8];
  longint      m_free [2];
  logic        m_last [2];
  logic        m_e0, m_e1, m_free_now;
  int          m_wc, found;
  logic [97:0] ent;
  logic [63:0] prod_s;

  avalon_mm_mult_scheduler #(.SZ(32), .WAIT_CYC(W0)) dut0 (
    .clk(clk), ._rst(_rst),
    .req0_valid(rv[0][0]), .req0_a(ra[0][0]), .req0_b(rb[0][0]), .req0_ready(rr[0][0]),
    .req1_valid(rv[0][1]), .req1_a(ra[0][1]), .req1_b(rb[0][1]), .req1_ready(rr[0][1]),
    .rsp0_valid(sv[0][0]), .rsp0_res(sres[0][0]),
    .rsp1_valid(sv[0][1]), .rsp1_res(sres[0][1]),
    .addr(addr[0]), .read(rd[0]), .write(wr[0]), .write_data(wdata[0]),
    .read_data(rdata[0]), .busy(busy[0]), .dbg(dbg[0])
  );

  avalon_mm_mult_scheduler #(.SZ(32), .WAIT_CYC(W1)) dut1 (
    .clk(clk), ._rst(_rst),
    .req0_valid(rv[1][0]), .req0_a(ra[1][0]), .req0_b(rb[1][0]), .req0_ready(rr[1][0]),
    .req1_valid(rv[1][1]), .req1_a(ra[1][1]), .req1_b(rb[1][1]), .req1_ready(rr[1][1]),
    .rsp0_valid(sv[1][0]), .rsp0_res(sres[1][0]),
    .rsp1_valid(sv[1][1]), .rsp1_res(sres[1][1]),
    .addr(addr[1]), .read(rd[1]), .write(wr[1]), .write_data(wdata[1]),
    .read_data(rdata[1]), .busy(busy[1]), .dbg(dbg[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------- behavioural multiplier slave ----------------
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      prod_s = {32'd0, sregs[k][1], sregs[k][0]} * {32'd0, sregs[k][3], sregs[k][2]};
      if (wr[k]) sregs[k][addr[k][2:0]] <= wdata[k];
      if (rd[k]) rdata[k] <= prod_s[16*addr[k][1:0] +: 16];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // An idle scheduler is free from the cycle of the previous accept + 10 + W.
  always @(negedge clk) begin
    if (!_rst) begin
      exp_q.delete();
      m_free = '{0, 0};
      m_last = '{1'b1, 1'b1};
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_wc       = (k == 0) ? W0 : W1;
        m_free_now = (cyc >= m_free[k]);
        m_e0 = m_free_now && rv[k][0] && (!rv[k][1] ||  m_last[k]);
        m_e1 = m_free_now && rv[k][1] && (!rv[k][0] || !m_last[k]);
        n_checks++;
        if (rr[k][0] !== m_e0 || rr[k][1] !== m_e1) begin
          n_fail++;
          $display("FAIL ready inst %0d cyc %0d: got %b%b, required %b%b",
                   k, cyc, rr[k][1], rr[k][0], m_e1, m_e0);
        end
        n_checks++;
        if (rr[k][0] === 1'b1 && rr[k][1] === 1'b1) begin
          n_fail++;
          $display("FAIL ready_onehot inst %0d cyc %0d: got both ready, required at most one", k, cyc);
        end
        n_checks++;
        if (rd[k] === 1'b1 && wr[k] === 1'b1) begin
          n_fail++;
          $display("FAIL rd_wr_excl inst %0d cyc %0d: got read=write=1, required not both", k, cyc);
        end
        if (m_e0 || m_e1) begin
          n_accept++;
          exp_q.push_back({1'(k), m_e1, 32'(cyc + 10 + m_wc),
                           {32'd0, ra[k][m_e1]} * {32'd0, rb[k][m_e1]}});
          m_last[k] = m_e1;
          m_free[k] = cyc + 10 + m_wc;
        end
        if (k == 0 && wr[0] === 1'b1) wlog.push_back({addr[0], wdata[0]});
        for (int p = 0; p < 2; p++) begin
          if (sv[k][p] === 1'b1) begin
            found = -1;
            foreach (exp_q[i]) if (found < 0 && exp_q[i][97] == 1'(k)) found = i;
            n_checks++;
            if (found < 0) begin
              n_fail++;
              $display("FAIL rsp_unexpected inst %0d port %0d cyc %0d: got pulse, required none", k, p, cyc);
            end else begin
              ent = exp_q[found];
              exp_q.delete(found);
              if (ent[96] !== 1'(p) || ent[63:0] !== sres[k][p] || ent[95:64] !== 32'(cyc)) begin
                n_fail++;
                $display("FAIL rsp_match inst %0d: got port %0d res %h cyc %0d, required port %0d res %h cyc %0d",
                         k, p, sres[k][p], cyc, ent[96], ent[63:0], ent[95:64]);
              end
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        rv[k][p] = 1'b0;
        ra[k][p] = 32'd0;
        rb[k][p] = 32'd0;
      end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    _rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    _rst = 1'b1;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) ok = 1'b1;
    end
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (addr[k] !== 4'd0 || rd[k] !== 1'b0 || wr[k] !== 1'b0 || wdata[k] !== 16'd0 || busy[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_bus inst %0d: got addr %h rd %b wr %b wdata %h busy %b, required all 0",
                 k, addr[k], rd[k], wr[k], wdata[k], busy[k]);
      end
      n_checks++;
      if (sv[k][0] !== 1'b0 || sv[k][1] !== 1'b0 || sres[k][0] !== 64'd0 || sres[k][1] !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_rsp inst %0d: got valid %b%b res %h %h, required all 0",
                 k, sv[k][1], sv[k][0], sres[k][1], sres[k][0]);
      end
      n_checks++;
      if (dbg[k].state !== ST_IDLE || dbg[k].last_grant !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_state inst %0d: got state %0d last_grant %b, required IDLE and 1",
                 k, dbg[k].state, dbg[k].last_grant);
      end
    end
    @(posedge clk); #1;
    _rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy[0] !== 1'b0 || rr[0][0] !== 1'b0 || rr[0][1] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy %b ready %b%b, required 0 and 00", busy[0], rr[0][1], rr[0][0]);
    end
  endtask

  task automatic test_basic();
    logic [19:0] exp_w [4];
    longint t;
    bit got;
    exp_w = '{{4'd0, 16'h0002}, {4'd1, 16'h0001}, {4'd2, 16'h0003}, {4'd3, 16'h0000}};
    wlog.delete();
    @(posedge clk); #1;
    rv[0][0] = 1'b1; ra[0][0] = 32'h0001_0002; rb[0][0] = 32'h0000_0003;
    got = 1'b0; t = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rr[0][0] === 1'b1) begin got = 1'b1; t = cyc; end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL basic_accept: got no ready in 20 cycles, required accept"); end
    @(posedge clk); #1;
    rv[0][0] = 1'b0; ra[0][0] = $urandom(); rb[0][0] = $urandom();
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (sv[0][0] === 1'b1 || sv[0][1] === 1'b1) begin
        got = 1'b1;
        n_checks++;
        if (cyc != t + 14 || sv[0][0] !== 1'b1 || sv[0][1] !== 1'b0 || sres[0][0] !== 64'h0000_0000_0003_0006) begin
          n_fail++;
          $display("FAIL basic_rsp: got cyc %0d valid %b%b res %h, required cyc %0d valid 01 res 0000000000030006",
                   cyc, sv[0][1], sv[0][0], sres[0][0], t + 14);
        end
      end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL basic_rsp_timeout: got no rsp in 40 cycles, required one"); end
    n_checks++;
    if (wlog.size() != 4) begin
      n_fail++;
      $display("FAIL basic_wcount: got %0d writes, required 4", wlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (wlog[i] !== exp_w[i]) begin
          n_fail++;
          $display("FAIL basic_write%0d: got addr/data %h, required %h", i, wlog[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_max();
    bit got;
    @(posedge clk); #1;
    rv[0][1] = 1'b1; ra[0][1] = 32'hFFFF_FFFF; rb[0][1] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rv[0][1] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (sv[0][1] === 1'b1) begin
        got = 1'b1;
        n_checks++;
        if (sres[0][1] !== 64'hFFFF_FFFE_0000_0001 || sv[0][0] !== 1'b0) begin
          n_fail++;
          $display("FAIL max_rsp: got res %h other valid %b, required FFFFFFFE00000001 and 0",
                   sres[0][1], sv[0][0]);
        end
      end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL max_rsp_timeout: got no rsp1, required one"); end
  endtask

  task automatic test_tie();
    int seq[$];
    int exp_order[3] = '{0, 1, 0};
    bit ok;
    pulse_reset();
    for (int p = 0; p < 2; p++) begin
      rv[0][p] = 1'b1; ra[0][p] = $urandom(); rb[0][p] = $urandom();
    end
    for (int i = 0; i < 80 && seq.size() < 3; i++) begin
      @(negedge clk);
      if (sv[0][0] === 1'b1 || sv[0][1] === 1'b1) begin
        n_checks++;
        if (sv[0][0] === 1'b1 && sv[0][1] === 1'b1) begin
          n_fail++;
          $display("FAIL tie_both_rsp cyc %0d: got both rsp valid, required one port only", cyc);
        end
        seq.push_back(sv[0][1] === 1'b1 ? 1 : 0);
      end
    end
    @(posedge clk); #1;
    rv[0][0] = 1'b0; rv[0][1] = 1'b0;
    n_checks++;
    if (seq.size() != 3) begin
      n_fail++;
      $display("FAIL tie_count: got %0d responses, required 3", seq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (seq[i] != exp_order[i]) begin
          n_fail++;
          $display("FAIL tie_order%0d: got port %0d, required port %0d", i, seq[i], exp_order[i]);
        end
      end
    end
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL tie_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] p1, p2;
    longint t;
    bit got;
    a1 = rand_op(); b1 = rand_op(); a2 = rand_op(); b2 = rand_op();
    p1 = {32'd0, a1} * {32'd0, b1};
    p2 = {32'd0, a2} * {32'd0, b2};
    @(posedge clk); #1;
    rv[1][0] = 1'b1; ra[1][0] = a1; rb[1][0] = b1;
    got = 1'b0; t = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rr[1][0] === 1'b1) begin got = 1'b1; t = cyc; end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL b2b_accept: got no ready, required accept"); end
    @(posedge clk); #1;
    ra[1][0] = a2; rb[1][0] = b2;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      else @(negedge clk);
      n_checks++;
      if (k <= 4 && (wr[1] !== 1'b1 || rd[1] !== 1'b0 || addr[1] !== 4'(k - 1))) begin
        n_fail++;
        $display("FAIL b2b_write T+%0d: got wr %b rd %b addr %0d, required wr 1 addr %0d", k, wr[1], rd[1], addr[1], k - 1);
      end else if (k >= 5 && k <= 8 && (rd[1] !== 1'b1 || wr[1] !== 1'b0 || addr[1] !== 4'(k - 1))) begin
        n_fail++;
        $display("FAIL b2b_read T+%0d: got wr %b rd %b addr %0d, required rd 1 addr %0d", k, wr[1], rd[1], addr[1], k - 1);
      end else if (k == 9 && (rd[1] !== 1'b0 || wr[1] !== 1'b0 || addr[1] !== 4'd0)) begin
        n_fail++;
        $display("FAIL b2b_rlast: got wr %b rd %b addr %0d, required 0 0 0", wr[1], rd[1], addr[1]);
      end else if (k == 10 && (sv[1][0] !== 1'b1 || sres[1][0] !== p1 || rr[1][0] !== 1'b1)) begin
        n_fail++;
        $display("FAIL b2b_rsp1: got valid %b res %h ready %b, required 1 %h 1", sv[1][0], sres[1][0], rr[1][0], p1);
      end
    end
    @(posedge clk); #1;
    rv[1][0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (sv[1][0] === 1'b1) begin
        got = 1'b1;
        n_checks++;
        if (cyc != t + 20 || sres[1][0] !== p2) begin
          n_fail++;
          $display("FAIL b2b_rsp2: got cyc %0d res %h, required cyc %0d res %h", cyc, sres[1][0], t + 20, p2);
        end
      end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL b2b_rsp2_timeout: got no rsp, required one"); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    logic [63:0] p;
    bit got;
    a = rand_op(); b = rand_op();
    p = {32'd0, a} * {32'd0, b};
    @(posedge clk); #1;
    rv[0][1] = 1'b1; ra[0][1] = a; rb[0][1] = b;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rr[0][1] === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL mid_accept: got no ready, required accept"); end
    // Accept cycle T; RD beat 2 is T+5+W+2.
    repeat (5 + W0 + 2) @(posedge clk);
    #2;
    n_checks++;
    if (rd[0] !== 1'b1 || addr[0] !== 4'd6) begin
      n_fail++;
      $display("FAIL mid_position: got rd %b addr %0d, required rd 1 addr 6", rd[0], addr[0]);
    end
    _rst = 1'b0;
    #1;
    n_checks++;
    if (addr[0] !== 4'd0 || rd[0] !== 1'b0 || wr[0] !== 1'b0 || wdata[0] !== 16'd0 || busy[0] !== 1'b0 ||
        sv[0][0] !== 1'b0 || sv[0][1] !== 1'b0 || sres[0][1] !== 64'd0 || dbg[0].state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL mid_async_clear: got addr %0d rd %b wr %b wdata %h busy %b rsp %b%b res %h, required all 0",
               addr[0], rd[0], wr[0], wdata[0], busy[0], sv[0][1], sv[0][0], sres[0][1]);
    end
    @(posedge clk); @(posedge clk); #1;
    _rst = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (sv[0][1] === 1'b1) begin
        got = 1'b1;
        n_checks++;
        if (sres[0][1] !== p) begin
          n_fail++;
          $display("FAIL mid_retry_rsp: got res %h, required %h", sres[0][1], p);
        end
      end
      if (rr[0][1] === 1'b1) begin
        @(posedge clk); #1;
        rv[0][1] = 1'b0;
      end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL mid_retry_timeout: got no rsp, required one"); end
  endtask

  task automatic test_random();
    int acc0;
    bit ok;
    acc0 = n_accept;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++) begin
          rv[k][p] = ($urandom_range(0, 2) != 0);
          ra[k][p] = rand_op();
          rb[k][p] = rand_op();
        end
    end
    @(posedge clk); #1;
    clear_inputs();
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL random_drain: got %0d pending, required 0", exp_q.size()); end
    n_checks++;
    if (n_accept - acc0 < 20) begin
      n_fail++;
      $display("FAIL random_activity: got %0d accepts, required at least 20", n_accept - acc0);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    _rst = 1'b0;
    clear_inputs();
    for (int k = 0; k < 2; k++) begin
      rdata[k] = 16'd0;
      for (int j = 0; j < 8; j++) sregs[k][j] = 16'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_max();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (5) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rsp_per_accept: got %0d accepts without response, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_mm_mult_scheduler.md
# avalon_mm_mult_scheduler

Two-requester scheduler that shares one Avalon-MM multiplier slave (16-bit data, word addresses 0-7: A lo/hi, B lo/hi, C0..C3) between two client ports. It arbitrates round-robin, latches the granted operands, and drives the four-beat write / wait / four-beat read sequence. It returns the 64-bit product to the winning client as a one-cycle response pulse. It sits between client logic and the slave wrapper, replacing a free-running fixed-sequence master.

## Interface
- SZ, 32: operand width. Only 32 is supported, because the address map holds two halfwords per operand.
- WAIT_CYC, 4: idle cycles between the last write and the first read, covering multiplier latency. Range 0..255.
- clk  in  1  clock
- _rst  in  1  reset, asynchronous, active-low
- req0_valid / req1_valid  in  1  client N has an operand pair pending
- req0_a, req0_b / req1_a, req1_b  in  SZ  operands; sampled only on the accept edge
- req0_ready / req1_ready  out  1  accept strobe; a transfer occurs when valid && ready
- rsp0_valid / rsp1_valid  out  1  one-cycle pulse: product for client N available
- rsp0_res / rsp1_res  out  2*SZ  product for client N; holds until the next response to the same port
- addr  out  4  Avalon address
- read, write  out  1  Avalon strobes; never high together
- write_data  out  16  Avalon write data
- read_data  in  16  Avalon read data, valid the cycle after read is high
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE → WR → WAIT → RD → RLAST → IDLE.
  - IDLE: combinational readyN = (state==IDLE) && grant==N && reqN_valid.
    - On accept: latch a_q, b_q; record owner = N; go to WR with beat=0.
  - WR: beats 0..3 drive addr=beat, write=1, write_data = a_q[15:0], a_q[31:16], b_q[15:0], b_q[31:16].
    - After beat 3, go to WAIT; if WAIT_CYC==0, go directly to RD.
  - WAIT: count down WAIT_CYC cycles with read=write=0.
  - RD: beats 0..3 drive addr=4+beat, read=1.
    - In RD beats 1..3, capture read_data into acc[16*(beat-1) +: 16].
  - RLAST: read=0, addr=0.
    - Set rspOWNER_res = {read_data, acc[47:0]} and rspOWNER_valid=1 for one cycle.
    - Return to IDLE.
- Arbitration: 2-way round-robin with last_grant register.
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins.
  - last_grant resets to 1, so req0 wins the first tie.
  - last_grant updates only on accept.
- Result width: full unsigned 64-bit product, assembled verbatim from C0..C3; no truncation.
- Operand changes after accept have no effect on the in-flight transaction.

## Timing
- All Avalon outputs, rsp*, and busy are registered.
- Reset values: addr=0, read=0, write=0, write_data=0, rsp*_valid=0, rsp*_res=0, busy=0, state=IDLE, last_grant=1, acc=0.
- Accept in cycle T:
  - writes occupy cycles T+1..T+4;
  - wait occupies T+5..T+4+W;
  - reads (addr 4..7) occupy T+5+W..T+8+W;
  - rsp_valid is high in cycle T+10+W.
- Occupancy is 10+W cycles.
- A new accept is possible in the same cycle as rsp_valid, which is back-to-back issue.
- rsp pulse to port N and reqN_valid in the same cycle: the request is eligible normally.
- A requester that drops valid before ready is not served; no state is retained.
- Reset asserted mid-transaction clears all state immediately:
  - partial result discarded;
  - no response pulse;
  - pending requests re-arbitrate after release.

## Structure
- Package avalon_mult_pkg:
  - state enum;
  - address constants ADDR_A0=0, ADDR_A1=1, ADDR_B0=2, ADDR_B1=3, ADDR_C0..ADDR_C3=4..7;
  - NBEATS=4.
- Sub-module rr_arbiter_2: inputs req[1:0] and advance; outputs grant index and last_grant register.

## Test plan
- Basic product (WAIT_CYC=4):
  - Stimulus: req0 A=0x0001_0002, B=0x0000_0003, driven against a behavioural slave.
  - Required writes: (0,0x0002), (1,0x0001), (2,0x0003), (3,0x0000).
  - Required response: rsp0_res=0x0000_0000_0003_0006 at T+14.
- Maximum operands: A=B=0xFFFF_FFFF → rsp_res=0xFFFF_FFFE_0000_0001.
- Tie arbitration:
  - Both valid and held after reset → grant order req0, req1, req0.
  - Each response lands on the correct port only; the other rsp_valid stays 0.
- WAIT_CYC=0 back-to-back:
  - Reads immediately follow writes.
  - rsp at T+10.
  - A second accept occurs in the rsp cycle.
- Reset mid-transaction:
  - _rst low during RD beat 2 → all outputs 0 asynchronously; no rsp pulse.
  - After release, the same request completes correctly.
- Protocol assertions, checked throughout:
  - read and write are never both high;
  - at most one ready is high per cycle;
  - exactly one rsp pulse per accept.
